// File: rtl/pcie_sl3_tx_framer_pkg.sv
// rtl/pcie_sl3_tx_framer_pkg.sv - shared types, header layout and helpers for the SL3 TX framer
// Optional trailer phit is enabled with PCIE_SL3_TRAILER_EN.
package PcieSl3Types;

  localparam int PCIE_DATA_WIDTH = 64;
  localparam int PHIT_WIDTH      = 64;
  localparam int SLOT_W          = 8;
  localparam int PAD_W           = 8;
  localparam int BEATS_W         = 16;
  localparam int DESC_START_W    = 16;

  localparam logic [7:0] SL3F_MARKER = 8'hC5;

  // Header phit field offsets
  localparam int HDR_MARKER_LSB = 0;
  localparam int HDR_SLOT_LSB   = 8;
  localparam int HDR_PAD_LSB    = 16;
  localparam int HDR_BEATS_LSB  = 24;

`ifdef PCIE_SL3_TRAILER_EN
  localparam logic TRAILER_EN = 1'b1;
`else
  localparam logic TRAILER_EN = 1'b0;
`endif

  typedef struct packed {
    logic                       valid;
    logic [PCIE_DATA_WIDTH-1:0] data;
    logic [SLOT_W-1:0]          slot;
    logic [PAD_W-1:0]           pad;
    logic                       last;
  } PCIEPacket;

  typedef struct packed {
    logic                  valid;
    logic [PHIT_WIDTH-1:0] data;
    logic                  last;
  } SL3DataInterface;

  typedef struct packed {
    logic [DESC_START_W-1:0] start;
    logic [BEATS_W-1:0]      beats;
    logic [SLOT_W-1:0]       slot;
    logic [PAD_W-1:0]        pad;
`ifdef PCIE_SL3_TRAILER_EN
    logic [PHIT_WIDTH-1:0]   csum;
`endif
  } Sl3fDesc;

  typedef enum logic [1:0] {TX_IDLE, TX_HDR, TX_BODY, TX_TRL} TxState;
  typedef enum logic       {IN_ACCEPT, IN_DROP} InState;

  function automatic logic [PHIT_WIDTH-1:0] sl3f_header(input logic [SLOT_W-1:0]  slot,
                                                         input logic [PAD_W-1:0]   pad,
                                                         input logic [BEATS_W-1:0] beats,
                                                         input logic               trl);
    logic [PHIT_WIDTH-1:0] h;
    h = '0;
    h[HDR_MARKER_LSB +: 8]      = SL3F_MARKER;
    h[HDR_SLOT_LSB   +: SLOT_W] = slot;
    h[HDR_PAD_LSB    +: PAD_W]  = pad;
    h[HDR_BEATS_LSB  +: BEATS_W] = beats;
    h[PHIT_WIDTH-1]             = trl;
    return h;
  endfunction

endpackage

// File: rtl/pcie_sl3_tx_framer_desc_fifo.sv
// rtl/pcie_sl3_tx_framer_desc_fifo.sv - single-clock FIFO of committed-packet descriptors
module sl3f_desc_fifo
  import PcieSl3Types::*;
#(
  parameter int DEPTH = 8
) (
  input  logic    clk_i,
  input  logic    rst_ni,
  input  logic    push_i,
  input  Sl3fDesc push_desc_i,
  input  logic    pop_i,
  output logic    full_o,
  output logic    empty_o,
  output Sl3fDesc head_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

  logic [AW:0] wr_q, wr_d, rd_q, rd_d;
  logic        do_push, do_pop;
  Sl3fDesc     mem_q [DEPTH];

  assign full_o  = (wr_q - rd_q) == DEPTH_CNT;
  assign empty_o = wr_q == rd_q;
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign wr_d    = wr_q + (AW+1)'(do_push);
  assign rd_d    = rd_q + (AW+1)'(do_pop);
  assign head_o  = mem_q[rd_q[AW-1:0]];

  // Read/write pointers; push and pop in the same cycle both take effect
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Descriptor storage, no reset needed since pointers gate visibility
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= push_desc_i;
  end

endmodule

// File: rtl/pcie_sl3_tx_framer.sv
// rtl/pcie_sl3_tx_framer.sv - store-and-forward PCIe beat to SL3 phit framer with oversize drop
// Optional trailer phit (XOR of body beats) is enabled with PCIE_SL3_TRAILER_EN.
module pcie_sl3_tx_framer
  import PcieSl3Types::*;
#(
  parameter int DEPTH         = 64,
  parameter int DESC_DEPTH    = 8,
  parameter int MAX_PKT_BEATS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  PCIEPacket       pcie_packet_in,
  output logic            pcie_full_out,
  output SL3DataInterface sl_tx_out,
  input  logic            sl_tx_full_in,
  output logic [31:0]     stat_pkts_out,
  output logic [31:0]     stat_drops_out
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0]      DEPTH_CNT = PW'(DEPTH);
  localparam logic [BEATS_W-1:0] MAX_BEATS = BEATS_W'(MAX_PKT_BEATS);

  if (PHIT_WIDTH != PCIE_DATA_WIDTH) begin : g_width_err
    $error("pcie_sl3_tx_framer: PHIT_WIDTH must equal PCIE_DATA_WIDTH");
  end
  if (MAX_PKT_BEATS >= DEPTH) begin : g_max_err
    $error("pcie_sl3_tx_framer: MAX_PKT_BEATS must be smaller than DEPTH");
  end

  logic [PW-1:0]      spec_wr_q, spec_wr_d, commit_wr_q, commit_wr_d, rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]      occupancy;
  logic [BEATS_W-1:0] beat_cnt_q, beat_cnt_d, body_cnt_q, body_cnt_d;
  InState             in_state_q, in_state_d;
  TxState             tx_state_q, tx_state_d;
  logic [31:0]        pkts_q, pkts_d, drops_q, drops_d;
  logic               beat_acc, buf_we, desc_push, desc_pop, desc_full, desc_empty;
  logic               tx_valid, tx_last_body;
  Sl3fDesc            desc_new, desc_head;
  logic [PHIT_WIDTH-1:0] buf_mem [DEPTH];
`ifdef PCIE_SL3_TRAILER_EN
  logic [PHIT_WIDTH-1:0] csum_acc_q, csum_acc_d, trl_csum_q, trl_csum_d;
`endif
  logic unused_start_bits;

  assign unused_start_bits = ^desc_head.start[DESC_START_W-1:PW];

  // Occupancy counts speculative beats too, so a packet in flight holds its space
  assign occupancy     = spec_wr_q - rd_ptr_q;
  assign pcie_full_out = (in_state_q == IN_ACCEPT) && ((occupancy == DEPTH_CNT) || desc_full);
  assign beat_acc      = pcie_packet_in.valid && !pcie_full_out;

  assign tx_valid      = (tx_state_q != TX_IDLE) && !sl_tx_full_in;
  assign tx_last_body  = (tx_state_q == TX_BODY) && (body_cnt_q == desc_head.beats - BEATS_W'(1));
  assign stat_pkts_out  = pkts_q;
  assign stat_drops_out = drops_q;

  // Descriptor for the packet whose last beat is being accepted this cycle
  always_comb begin
    desc_new       = '0;
    desc_new.start = DESC_START_W'(commit_wr_q);
    desc_new.beats = beat_cnt_q + BEATS_W'(1);
    desc_new.slot  = pcie_packet_in.slot;
    desc_new.pad   = pcie_packet_in.pad;
`ifdef PCIE_SL3_TRAILER_EN
    desc_new.csum  = csum_acc_q ^ pcie_packet_in.data;
`endif
  end

  // Ingress: store beats speculatively, commit on last, rewind on oversize
  always_comb begin
    spec_wr_d   = spec_wr_q;
    commit_wr_d = commit_wr_q;
    beat_cnt_d  = beat_cnt_q;
    in_state_d  = in_state_q;
    drops_d     = drops_q;
    buf_we      = 1'b0;
    desc_push   = 1'b0;
`ifdef PCIE_SL3_TRAILER_EN
    csum_acc_d  = csum_acc_q;
`endif
    if (beat_acc) begin
      if (in_state_q == IN_DROP) begin
        if (pcie_packet_in.last) begin
          drops_d    = drops_q + 32'd1;
          in_state_d = IN_ACCEPT;
        end
      end else if (beat_cnt_q == MAX_BEATS) begin
        spec_wr_d  = commit_wr_q;
        beat_cnt_d = '0;
`ifdef PCIE_SL3_TRAILER_EN
        csum_acc_d = '0;
`endif
        if (pcie_packet_in.last) drops_d = drops_q + 32'd1;
        else                     in_state_d = IN_DROP;
      end else begin
        buf_we     = 1'b1;
        spec_wr_d  = spec_wr_q + PW'(1);
        beat_cnt_d = beat_cnt_q + BEATS_W'(1);
`ifdef PCIE_SL3_TRAILER_EN
        csum_acc_d = csum_acc_q ^ pcie_packet_in.data;
`endif
        if (pcie_packet_in.last) begin
          desc_push   = 1'b1;
          commit_wr_d = spec_wr_q + PW'(1);
          beat_cnt_d  = '0;
`ifdef PCIE_SL3_TRAILER_EN
          csum_acc_d  = '0;
`endif
        end
      end
    end
  end

  // TX FSM: header, body read from buffer, optional trailer
  always_comb begin
    tx_state_d = tx_state_q;
    rd_ptr_d   = rd_ptr_q;
    body_cnt_d = body_cnt_q;
    pkts_d     = pkts_q;
    desc_pop   = 1'b0;
`ifdef PCIE_SL3_TRAILER_EN
    trl_csum_d = trl_csum_q;
`endif
    case (tx_state_q)
      TX_IDLE: if (!desc_empty) tx_state_d = TX_HDR;
      TX_HDR: begin
        if (tx_valid) begin
          tx_state_d = TX_BODY;
          rd_ptr_d   = desc_head.start[PW-1:0];
          body_cnt_d = '0;
        end
      end
      TX_BODY: begin
        if (tx_valid) begin
          rd_ptr_d   = rd_ptr_q + PW'(1);
          body_cnt_d = body_cnt_q + BEATS_W'(1);
          if (tx_last_body) begin
            desc_pop   = 1'b1;
            body_cnt_d = '0;
`ifdef PCIE_SL3_TRAILER_EN
            trl_csum_d = desc_head.csum;
            tx_state_d = TX_TRL;
`else
            pkts_d     = pkts_q + 32'd1;
            tx_state_d = TX_IDLE;
`endif
          end
        end
      end
      TX_TRL: begin
        if (tx_valid) begin
          pkts_d     = pkts_q + 32'd1;
          tx_state_d = TX_IDLE;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  // Output phit mux; data is zero whenever the FSM is idle
  always_comb begin
    sl_tx_out       = '0;
    sl_tx_out.valid = tx_valid;
    case (tx_state_q)
      TX_HDR:  sl_tx_out.data = sl3f_header(desc_head.slot, desc_head.pad, desc_head.beats, TRAILER_EN);
      TX_BODY: begin
        sl_tx_out.data = buf_mem[rd_ptr_q[AW-1:0]];
        sl_tx_out.last = tx_valid && tx_last_body && !TRAILER_EN;
      end
`ifdef PCIE_SL3_TRAILER_EN
      TX_TRL: begin
        sl_tx_out.data = trl_csum_q;
        sl_tx_out.last = tx_valid;
      end
`endif
      default: ;
    endcase
  end

  // State, pointer and statistics registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      spec_wr_q   <= '0;
      commit_wr_q <= '0;
      rd_ptr_q    <= '0;
      beat_cnt_q  <= '0;
      body_cnt_q  <= '0;
      in_state_q  <= IN_ACCEPT;
      tx_state_q  <= TX_IDLE;
      pkts_q      <= '0;
      drops_q     <= '0;
`ifdef PCIE_SL3_TRAILER_EN
      csum_acc_q  <= '0;
      trl_csum_q  <= '0;
`endif
    end else begin
      spec_wr_q   <= spec_wr_d;
      commit_wr_q <= commit_wr_d;
      rd_ptr_q    <= rd_ptr_d;
      beat_cnt_q  <= beat_cnt_d;
      body_cnt_q  <= body_cnt_d;
      in_state_q  <= in_state_d;
      tx_state_q  <= tx_state_d;
      pkts_q      <= pkts_d;
      drops_q     <= drops_d;
`ifdef PCIE_SL3_TRAILER_EN
      csum_acc_q  <= csum_acc_d;
      trl_csum_q  <= trl_csum_d;
`endif
    end
  end

  // Body buffer write port; read is asynchronous at rd_ptr
  always_ff @(posedge clk) begin
    if (buf_we) buf_mem[spec_wr_q[AW-1:0]] <= pcie_packet_in.data;
  end

  sl3f_desc_fifo #(
    .DEPTH(DESC_DEPTH)
  ) u_desc_fifo (
    .clk_i      (clk),
    .rst_ni     (rst),
    .push_i     (desc_push),
    .push_desc_i(desc_new),
    .pop_i      (desc_pop),
    .full_o     (desc_full),
    .empty_o    (desc_empty),
    .head_o     (desc_head)
  );

endmodule
